// File: rtl/ddr_rd_stream_pkg.sv
// Shared parameters for the DDR read streamer: beat width, the bit-width
// helper and the controller state encoding.
package ddr_rd_stream_pkg;

    localparam int DDR_W      = 256;
    localparam int BEAT_BYTES = DDR_W / 8;
    localparam int BEAT_SH    = $clog2(BEAT_BYTES);

    // Bits needed to hold the value x (at least 1).
    function automatic int bw(input int x);
        return (x < 2) ? 1 : $clog2(x + 1);
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } rd_state_t;

endpackage

// File: rtl/ddr_rd_stream_sfifo.sv
// Synchronous FIFO with registered read port and occupancy count.
// A pop on an empty FIFO with a simultaneous push passes the write data straight to rdata.
module sfifo
    import ddr_rd_stream_pkg::*;
#(
    parameter int W     = DDR_W,
    parameter int DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [W-1:0]           wdata,
    input  logic                   pop,
    output logic [W-1:0]           rdata,
    output logic [bw(DEPTH)-1:0]   count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = bw(DEPTH - 1);
    localparam int CW = bw(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;
    logic          bypass;
    logic          wr;
    logic          rd;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && (!empty || push);
    assign bypass  = do_pop && empty;
    assign wr      = do_push && !bypass;
    assign rd      = do_pop && !bypass;

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            rdata <= '0;
            count <= '0;
        end else begin
            if (wr) begin
                wptr <= wptr + AW'(1);
            end
            if (rd) begin
                rptr <= rptr + AW'(1);
            end
            if (do_pop) begin
                rdata <= bypass ? wdata : mem[rptr];
            end
            case ({wr, rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ddr_rd_stream.sv
// Streams a contiguous DDR region out as beats: splits the transfer into
// boundary-respecting bursts, credits them against FIFO space, and forwards data in order.
module ddr_rd_stream
    import ddr_rd_stream_pkg::*;
#(
    parameter int DDR_AW     = 32,
    parameter int MAX_BURST  = 16,
    parameter int FIFO_DEPTH = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              done,
    input  logic [DDR_AW-1:0] conf_base_addr,
    input  logic [7:0]        conf_trans_num,
    output logic [DDR_AW-1:0] rd_addr,
    output logic [7:0]        rd_len,
    output logic              rd_addr_valid,
    input  logic              rd_addr_ready,
    input  logic [DDR_W-1:0]  rd_data,
    input  logic              rd_data_valid,
    output logic              rd_data_ready,
    output logic [DDR_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int MB_W  = bw(MAX_BURST - 1);
    localparam int CNT_W = bw(FIFO_DEPTH);
    localparam int CR_W  = bw(FIFO_DEPTH + MAX_BURST) + 1;

    rd_state_t         state;
    rd_state_t         state_next;
    logic [8:0]        req_left;
    logic [8:0]        beat_cnt;
    logic [8:0]        to_bound;
    logic [8:0]        beats;
    logic [7:0]        trans_num_q;
    logic [DDR_AW-1:0] req_addr;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  fifo_count;
    logic [CR_W-1:0]   demand;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic              ready_en;
    logic              req_hs;
    logic              data_hs;
    logic              out_hs;
    logic              last_req;
    logic              last_beat;
    logic              credit_ok;
    logic              issue;
    logic              start_ok;

    assign req_hs    = rd_addr_valid && rd_addr_ready;
    assign data_hs   = rd_data_valid && rd_data_ready;
    assign out_hs    = out_valid && out_ready;
    assign start_ok  = (state == ST_IDLE) && start;
    assign last_req  = req_hs && (req_left == (9'(rd_len) + 9'd1));
    assign last_beat = out_hs && (beat_cnt == {1'b0, trans_num_q});
    assign done      = (state == ST_IDLE);

    // A burst may not run past the next MAX_BURST-beat aligned address.
    assign to_bound  = 9'(MAX_BURST) - 9'(req_addr[BEAT_SH +: MB_W]);
    assign beats     = (req_left < to_bound) ? req_left : to_bound;

    // The output register counts as storage, so stored + in-flight never exceeds FIFO_DEPTH.
    assign demand    = CR_W'(fifo_count) + CR_W'(out_valid) + CR_W'(outstanding) + CR_W'(beats);
    assign credit_ok = (demand <= CR_W'(FIFO_DEPTH));
    assign issue     = (state == ST_REQ) && !rd_addr_valid && credit_ok;

    assign rd_data_ready = ready_en && !fifo_full;
    assign fifo_pop      = (!out_valid || out_ready) && (!fifo_empty || data_hs);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start)     state_next = ST_REQ;
            ST_REQ:  if (last_req)  state_next = ST_WAIT;
            ST_WAIT: if (last_beat) state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_addr      <= '0;
            req_left      <= '0;
            trans_num_q   <= '0;
            beat_cnt      <= '0;
            rd_addr_valid <= 1'b0;
            rd_addr       <= '0;
            rd_len        <= '0;
            outstanding   <= '0;
            out_valid     <= 1'b0;
            ready_en      <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (start_ok) begin
                req_addr    <= conf_base_addr;
                req_left    <= 9'(conf_trans_num) + 9'd1;
                trans_num_q <= conf_trans_num;
                beat_cnt    <= '0;
            end
            if (issue) begin
                rd_addr_valid <= 1'b1;
                rd_addr       <= req_addr;
                rd_len        <= 8'(beats - 9'd1);
            end else if (req_hs) begin
                rd_addr_valid <= 1'b0;
                req_addr      <= req_addr + ((DDR_AW'(rd_len) + DDR_AW'(1)) << BEAT_SH);
                req_left      <= req_left - (9'(rd_len) + 9'd1);
            end
            if (out_hs) begin
                beat_cnt <= beat_cnt + 9'd1;
            end
            outstanding <= outstanding
                         + (req_hs ? (CNT_W'(rd_len) + CNT_W'(1)) : '0)
                         - CNT_W'(data_hs);
            out_valid   <= fifo_pop || (out_valid && !out_ready);
        end
    end

    sfifo #(
        .W     (DDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (data_hs),
        .wdata (rd_data),
        .pop   (fifo_pop),
        .rdata (out_data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_ddr_rd_stream.sv
// Scoreboard bench for ddr_rd_stream: a randomised DDR slave and sink, a
// plain-arithmetic model of the expected bursts and beats, and a negedge monitor.
module tb_ddr_rd_stream;
    import ddr_rd_stream_pkg::*;

    localparam int AW     = 32;
    localparam int MAXB   = 16;
    localparam int DEPTH  = 64;
    localparam int BEAT_B = DDR_W / 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             done;
    logic [AW-1:0]    conf_base_addr;
    logic [7:0]       conf_trans_num;
    logic [AW-1:0]    rd_addr;
    logic [7:0]       rd_len;
    logic             rd_addr_valid;
    logic             rd_addr_ready;
    logic [DDR_W-1:0] rd_data;
    logic             rd_data_valid;
    logic             rd_data_ready;
    logic [DDR_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    ddr_rd_stream #(.DDR_AW(AW), .MAX_BURST(MAXB), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .done           (done),
        .conf_base_addr (conf_base_addr),
        .conf_trans_num (conf_trans_num),
        .rd_addr        (rd_addr),
        .rd_len         (rd_len),
        .rd_addr_valid  (rd_addr_valid),
        .rd_addr_ready  (rd_addr_ready),
        .rd_data        (rd_data),
        .rd_data_valid  (rd_data_valid),
        .rd_data_ready  (rd_data_ready),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int addr_pct = 100;
    int dv_pct = 100;
    int or_pct = 100;
    int epoch = 0;
    int accepted = 0;
    int delivered = 0;
    bit last_taken = 0;
    bit done_pend = 0;
    logic [39:0]      exp_req[$];
    logic [DDR_W-1:0] exp_beats[$];
    logic [31:0]      ddr_beats[$];

    task automatic chk(input string nm, input logic [DDR_W-1:0] act, input logic [DDR_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit pct(input int p);
        return int'($urandom_range(99, 0)) < p;
    endfunction

    function automatic logic [DDR_W-1:0] mk_data(input logic [31:0] a, input int ep);
        logic [DDR_W-1:0] d;
        for (int i = 0; i < DDR_W / 32; i++)
            d[32*i +: 32] = a ^ (32'(i) * 32'h1111_1111) ^ (32'(ep) << 24);
        return d;
    endfunction

    // Reference model: burst list and beat stream from base and beat count.
    task automatic build_expect(input logic [31:0] base, input int tn);
        int rem;
        int n;
        int to_b;
        logic [31:0] a;
        rem = tn + 1;
        a = base;
        while (rem > 0) begin
            to_b = (MAXB * BEAT_B - int'(a % (MAXB * BEAT_B))) / BEAT_B;
            n = (rem < MAXB) ? rem : MAXB;
            if (to_b < n) n = to_b;
            exp_req.push_back({a, 8'(n - 1)});
            a = a + 32'(n * BEAT_B);
            rem = rem - n;
        end
        for (int i = 0; i <= tn; i++)
            exp_beats.push_back(mk_data(base + 32'(i * BEAT_B), epoch));
    endtask

    // DDR slave and stream sink drivers.
    initial begin
        bit hold;
        rd_addr_ready = 1'b0;
        rd_data_valid = 1'b0;
        rd_data = '0;
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                rd_addr_ready = 1'b0;
                rd_data_valid = 1'b0;
                rd_data = '0;
                out_ready = 1'b0;
            end else begin
                rd_addr_ready = pct(addr_pct);
                hold = rd_data_valid && !last_taken;
                rd_data_valid = (ddr_beats.size() > 0) && (hold || pct(dv_pct));
                rd_data = (ddr_beats.size() > 0) ? mk_data(ddr_beats[0], epoch) : '0;
                out_ready = pct(or_pct);
            end
        end
    end

    // Monitor: protocol holds, latency, occupancy, and scoreboard pops.
    initial begin
        bit prev_av;
        bit prev_ov;
        bit prev_lat;
        logic [31:0] p_addr;
        logic [7:0] p_len;
        logic [DDR_W-1:0] p_od;
        logic [39:0] e;
        prev_av = 0; prev_ov = 0; prev_lat = 0;
        p_addr = '0; p_len = '0; p_od = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_av = 0; prev_ov = 0; prev_lat = 0; done_pend = 0; last_taken = 0;
            end else begin
                if (done_pend) begin
                    chk("done_after_last_beat", done, 1'b1);
                    done_pend = 0;
                end
                if (prev_lat) chk("first_beat_latency", out_valid, 1'b1);
                if (prev_av) begin
                    chk("req_valid_hold", rd_addr_valid, 1'b1);
                    chk("req_addr_hold", rd_addr, p_addr);
                    chk("req_len_hold", rd_len, p_len);
                end
                if (prev_ov) begin
                    chk("out_valid_hold", out_valid, 1'b1);
                    chk("out_data_hold", out_data, p_od);
                end
                chk("occupancy_bound", (accepted - delivered) <= DEPTH, 1'b1);
                if (rd_addr_valid && rd_addr_ready) begin
                    if (exp_req.size() == 0) begin
                        chk("unexpected_request", 1'b1, 1'b0);
                    end else begin
                        e = exp_req.pop_front();
                        chk("req_addr", rd_addr, e[39:8]);
                        chk("req_len", rd_len, e[7:0]);
                    end
                    for (int i = 0; i <= int'(rd_len); i++)
                        ddr_beats.push_back(rd_addr + 32'(i * BEAT_B));
                    accepted += int'(rd_len) + 1;
                end
                last_taken = rd_data_valid && rd_data_ready;
                if (last_taken && ddr_beats.size() > 0) void'(ddr_beats.pop_front());
                if (out_valid && out_ready) begin
                    delivered++;
                    if (exp_beats.size() == 0) begin
                        chk("unexpected_beat", 1'b1, 1'b0);
                    end else begin
                        chk("beat_data", out_data, exp_beats.pop_front());
                        if (exp_beats.size() == 0) begin
                            chk("done_low_at_last_beat", done, 1'b0);
                            done_pend = 1;
                        end
                    end
                end
                prev_av = rd_addr_valid && !rd_addr_ready;
                p_addr = rd_addr;
                p_len = rd_len;
                prev_ov = out_valid && !out_ready;
                p_od = out_data;
                prev_lat = rd_data_valid && rd_data_ready && out_ready;
            end
        end
    end

    task automatic check_reset_vals();
        chk("rst_done", done, 1'b1);
        chk("rst_addr_valid", rd_addr_valid, 1'b0);
        chk("rst_addr", rd_addr, '0);
        chk("rst_len", rd_len, '0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_data_ready", rd_data_ready, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_vals();
        exp_req.delete();
        exp_beats.delete();
        ddr_beats.delete();
        accepted = 0;
        delivered = 0;
        epoch++;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic launch(input logic [31:0] base, input int tn);
        build_expect(base, tn);
        @(posedge clk);
        #1;
        conf_base_addr = base;
        conf_trans_num = 8'(tn);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("done_low_after_start", done, 1'b0);
    endtask

    task automatic wait_done(input int budget);
        int c;
        c = 0;
        while (done !== 1'b1 && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (done !== 1'b1) begin
            chk("done_timeout", done, 1'b1);
            do_reset();
        end else begin
            chk("req_queue_drained", exp_req.size(), 0);
            chk("beat_queue_drained", exp_beats.size(), 0);
        end
        accepted = 0;
        delivered = 0;
    endtask

    initial begin
        int c;
        logic [31:0] b;
        rst_n = 1'b0;
        start = 1'b0;
        conf_base_addr = '0;
        conf_trans_num = '0;
        repeat (2) @(negedge clk);
        check_reset_vals();
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Aligned 64-beat transfer, all ready.
        launch(32'h1000, 63);
        wait_done(3000);

        // Single beat.
        launch(32'h2040, 0);
        wait_done(500);

        // Boundary-truncated first and last bursts.
        addr_pct = 60; dv_pct = 70; or_pct = 80;
        launch(32'h11C0, 19);
        wait_done(2000);

        // Long sink stall: requests must stop at FIFO capacity.
        addr_pct = 100; dv_pct = 100; or_pct = 0;
        launch(32'h8000, 255);
        repeat (200) @(negedge clk);
        chk("stall_accepted_beats", accepted, DEPTH);
        chk("stall_delivered", delivered, 0);
        chk("stall_no_request", rd_addr_valid, 1'b0);
        or_pct = 100;
        wait_done(3000);

        // Reset in the middle of WAIT, then a fresh 8-beat transfer.
        or_pct = 50;
        launch(32'h2000, 15);
        c = 0;
        while (!(accepted == 16 && delivered >= 3) && c < 2000) begin
            @(negedge clk);
            c++;
        end
        chk("reached_wait", (accepted == 16 && delivered >= 3), 1'b1);
        do_reset();
        or_pct = 100;
        launch(32'h3000, 7);
        wait_done(1000);

        // Start pulsed while requests are still being issued.
        addr_pct = 40; dv_pct = 80; or_pct = 90;
        launch(32'h4000, 63);
        c = 0;
        while (!rd_addr_valid && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk("in_req_state", rd_addr_valid, 1'b1);
        @(posedge clk);
        #1;
        conf_base_addr = 32'h00DE_AD00;
        conf_trans_num = 8'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(3000);

        // Random transfers with random pacing.
        for (int k = 0; k < 6; k++) begin
            b = $urandom;
            b = {12'h0, b[19:5], 5'b0};
            addr_pct = $urandom_range(100, 40);
            dv_pct = $urandom_range(100, 40);
            or_pct = $urandom_range(100, 40);
            launch(b, $urandom_range(255, 0));
            wait_done(4000);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ddr_rd_stream.md
DDR_RD_STREAM -- requirements
Module: ddr_rd_stream

Interface
REQ-001 SHALL have parameter DDR_AW, default 32, DDR byte-address width.
REQ-002 SHALL have parameter MAX_BURST, default 16, maximum beats per read request; power of two, at most FIFO_DEPTH.
REQ-003 SHALL have parameter FIFO_DEPTH, default 64, data FIFO entries; power of two.
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  sole clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle transfer launch.
- done  out  1  idle/complete flag.
- conf_base_addr  in  DDR_AW  byte address of the first beat; DDR_W/8-aligned.
- conf_trans_num  in  8  beats minus one, so 1..256 beats.
- rd_addr  out  DDR_AW  request address.
- rd_len  out  8  request beats minus one.
- rd_addr_valid  out  1  request valid.
- rd_addr_ready  in  1  request accepted.
- rd_data  in  DDR_W  returned beat.
- rd_data_valid  in  1  beat valid.
- rd_data_ready  out  1  beat accepted.
- out_data  out  DDR_W  stream beat to ddr2pbuf ddr1/ddr2 port.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream accepted.

Function
REQ-005 SHALL implement FSM IDLE, REQ, WAIT. IDLE->REQ on start. REQ->WAIT when the final request handshakes. WAIT->IDLE when the final beat handshakes on out_valid&&out_ready.
REQ-006 SHALL latch conf_base_addr and conf_trans_num on start in IDLE; start in any other state SHALL be ignored.
REQ-007 SHALL split total beats T=conf_trans_num+1 into requests of min(MAX_BURST, remaining) beats, and SHALL never cross a MAX_BURST*DDR_W/8 address boundary; a request truncated by the boundary ends at that boundary.
REQ-008 SHALL advance the request address by (rd_len+1)*DDR_W/8 bytes per accepted request.
REQ-009 SHALL raise rd_addr_valid only when FIFO free entries minus outstanding beats is at least the next request's beat count.
REQ-010 SHALL hold rd_addr_valid, rd_addr and rd_len stable until rd_addr_ready; no retraction.
REQ-011 SHALL add a request's beats to the outstanding count on its handshake, and SHALL subtract one on each rd_data handshake; both events in one cycle SHALL net correctly.
REQ-012 SHALL drive rd_data_ready high whenever the FIFO is not full; by REQ-009 this is always true for in-flight beats.
REQ-013 SHALL deliver beats on out_* in arrival order with standard valid/ready rules: out_valid and out_data hold until out_ready.
REQ-014 SHALL register out_*; first-beat latency from rd_data handshake to out_valid SHALL be exactly 1 cycle with out_ready high.
REQ-015 SHALL sustain one beat per cycle end to end when rd_data_valid and out_ready stay high.
REQ-016 SHALL count delivered beats and assert done in the cycle after the T-th out handshake.
REQ-017 SHALL drive done high in IDLE and low from the cycle after an accepted start.
REQ-018 SHALL handle FIFO push and pop in the same cycle, including at full and at empty, without loss or duplication.

Reset
REQ-019 SHALL, on rst_n low at any time, asynchronously clear to: state IDLE, done=1, rd_addr_valid=0, rd_addr=0, rd_len=0, out_valid=0, out_data=0, rd_data_ready=0, counters 0, FIFO empty.
REQ-020 SHALL discard in-flight requests and data on reset mid-transfer; the DDR interface is reset by the same rst_n.

Structure
REQ-021 SHALL take DDR_W and bw() from GLOBAL_PARAM; the FSM state enum SHALL be a typedef in GLOBAL_PARAM.
REQ-022 SHALL instantiate one sub-module, sfifo: a synchronous FIFO with async active-low reset, count output and registered read.

Verification
REQ-023 SHALL cover: base 0x1000, trans_num 63, ready always high -> 4 requests of len 15 at 0x1000, 0x1200, 0x1400 and 0x1600 (DDR_W=256); 64 beats in order; done after the last beat.
REQ-024 SHALL cover: trans_num 0 -> 1 request, len 0; 1 beat out; done rises 1 cycle after its handshake.
REQ-025 SHALL cover: base 0x11C0 (DDR_W=256), trans_num 19 -> requests len 1 at 0x11C0, len 15 at 0x1200, len 1 at 0x1400.
REQ-026 SHALL cover: out_ready low for 200 cycles, FIFO_DEPTH 64, trans_num 255 -> outstanding+stored never exceed 64; rd_addr_valid stalls; no beat lost when out_ready returns.
REQ-027 SHALL cover: rst_n low mid-WAIT, then start with trans_num 7 -> outputs at reset values, then exactly 8 fresh beats.
REQ-028 SHALL cover: start pulsed during REQ -> ignored; beat count and done timing unchanged.
